// File: rtl/mawg_play_scheduler.sv
// Play-request scheduler: queues {repetition, ctrl_length, start_delay} and sequences them onto one mawg.
// Latency: push at t into an empty queue with enable=1 -> pop at t+1, kick at t+3+start_delay.
// Backpressure: req_ready drops while the 2**QUEUE_DEPTH-entry FIFO is full; a kick is held while mawg_busy=1.
module mawg_play_scheduler #(
  parameter int CTRL_DEPTH  = 4,
  parameter int QUEUE_DEPTH = 3,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [15:0]                req_repetition,
  input  logic [2**CTRL_DEPTH-1:0]   req_ctrl_length,
  input  logic [DELAY_WIDTH-1:0]     req_delay,
  output logic                       mawg_kick,
  output logic [15:0]                mawg_repetition,
  output logic [2**CTRL_DEPTH-1:0]   mawg_ctrl_length,
  input  logic                       mawg_busy,
  output logic                       done,
  output logic                       done_skipped,
  output logic [QUEUE_DEPTH:0]       pending,
  output logic                       active
);

  localparam int LEN_W   = 2**CTRL_DEPTH;
  localparam int ENTRIES = 2**QUEUE_DEPTH;
  localparam logic [QUEUE_DEPTH:0] FULL_CNT = (QUEUE_DEPTH+1)'(ENTRIES);

  typedef struct packed {
    logic [15:0]            rep;
    logic [LEN_W-1:0]       len;
    logic [DELAY_WIDTH-1:0] delay;
  } req_t;

  typedef enum logic [1:0] {IDLE, DELAY, KICK, WAIT} state_t;

  // Request FIFO storage and pointers
  req_t                   mem [ENTRIES];
  req_t                   head;
  req_t                   wr_dat;
  logic [QUEUE_DEPTH-1:0] wr_ptr;
  logic [QUEUE_DEPTH-1:0] rd_ptr;
  logic                   push;
  logic                   pop;

  // Sequencer state and next-state values
  state_t                 state;
  state_t                 state_nxt;
  logic [DELAY_WIDTH-1:0] delay_cnt;
  logic [DELAY_WIDTH-1:0] cnt_nxt;
  logic [15:0]            rep_nxt;
  logic [LEN_W-1:0]       len_nxt;
  logic                   kick_nxt;
  logic                   done_nxt;
  logic                   skip_nxt;

  // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
  assign req_ready = (pending != FULL_CNT);
  assign push      = req_valid && req_ready && !flush;
  assign wr_dat    = '{rep: req_repetition, len: req_ctrl_length, delay: req_delay};
  assign head      = mem[rd_ptr];
  assign active    = (state != IDLE);

  // FIFO payload write; contents need no reset because pending gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // FIFO pointers and occupancy; flush discards everything not yet popped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else if (flush) begin
      rd_ptr  <= wr_ptr;
      pending <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + QUEUE_DEPTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + QUEUE_DEPTH'(1);
      end
      if (push && !pop) begin
        pending <= pending + (QUEUE_DEPTH+1)'(1);
      end else if (!push && pop) begin
        pending <= pending - (QUEUE_DEPTH+1)'(1);
      end
    end
  end

  // State register and registered outputs of the sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      delay_cnt        <= '0;
      mawg_repetition  <= '0;
      mawg_ctrl_length <= '0;
      mawg_kick        <= 1'b0;
      done             <= 1'b0;
      done_skipped     <= 1'b0;
    end else begin
      state            <= state_nxt;
      delay_cnt        <= cnt_nxt;
      mawg_repetition  <= rep_nxt;
      mawg_ctrl_length <= len_nxt;
      mawg_kick        <= kick_nxt;
      done             <= done_nxt;
      done_skipped     <= skip_nxt;
    end
  end

  // Next-state and next-output logic: pop, count down the delay, kick, wait for mawg to finish.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = delay_cnt;
    rep_nxt   = mawg_repetition;
    len_nxt   = mawg_ctrl_length;
    kick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    skip_nxt  = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && (pending != '0) && !flush) begin
          pop       = 1'b1;
          rep_nxt   = head.rep;
          len_nxt   = head.len;
          cnt_nxt   = head.delay;
          state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (delay_cnt == '0) begin
          state_nxt = KICK;
        end else begin
          cnt_nxt = delay_cnt - DELAY_WIDTH'(1);
        end
      end
      KICK: begin
        if (mawg_repetition == '0) begin
          done_nxt  = 1'b1;
          skip_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (!mawg_busy) begin
          kick_nxt  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // mawg_kick is high only in the first WAIT cycle, before mawg has registered its own busy.
        if (!mawg_kick && !mawg_busy) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mawg_play_scheduler.sv
// Bench for mawg_play_scheduler: directed scenarios plus randomized request batches.
// Expected kick/done cycles come from a request-level timing model; mawg is modelled as busy for a fixed time.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_mawg_play_scheduler;

  localparam int CTRL_DEPTH  = 4;
  localparam int QUEUE_DEPTH = 3;
  localparam int DELAY_WIDTH = 16;
  localparam int LEN_W       = 2**CTRL_DEPTH;
  localparam int BUSY_N      = 10;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   enable = 1'b0;
  logic                   flush = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [15:0]            req_repetition = '0;
  logic [LEN_W-1:0]       req_ctrl_length = '0;
  logic [DELAY_WIDTH-1:0] req_delay = '0;
  logic                   mawg_kick;
  logic [15:0]            mawg_repetition;
  logic [LEN_W-1:0]       mawg_ctrl_length;
  logic                   mawg_busy;
  logic                   done;
  logic                   done_skipped;
  logic [QUEUE_DEPTH:0]   pending;
  logic                   active;

  logic force_busy = 1'b0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   compared = 0;
  int   mismatched = 0;

  typedef struct { int c; int rep; int len; } kev_t;
  typedef struct { int c; int skip; } dev_t;

  kev_t kick_q[$];
  kev_t exp_kick[$];
  dev_t done_q[$];
  dev_t exp_done[$];
  int   kb = 0;
  int   ekb = 0;
  int   db = 0;
  int   edb = 0;
  int   last_done = 0;
  int   en_edge = 0;

  mawg_play_scheduler #(
    .CTRL_DEPTH (CTRL_DEPTH),
    .QUEUE_DEPTH(QUEUE_DEPTH),
    .DELAY_WIDTH(DELAY_WIDTH)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .flush           (flush),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_repetition  (req_repetition),
    .req_ctrl_length (req_ctrl_length),
    .req_delay       (req_delay),
    .mawg_kick       (mawg_kick),
    .mawg_repetition (mawg_repetition),
    .mawg_ctrl_length(mawg_ctrl_length),
    .mawg_busy       (mawg_busy),
    .done            (done),
    .done_skipped    (done_skipped),
    .pending         (pending),
    .active          (active)
  );

  always #5 clk = ~clk;

  // Cycle number = count of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // mawg model: busy = busy_r | kick, busy_r high for BUSY_N cycles after it sees the kick.
  always @(posedge clk) begin
    if (mawg_kick === 1'b1) busy_cnt <= BUSY_N;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign mawg_busy = force_busy | (mawg_kick === 1'b1) | (busy_cnt != 0);

  // Event recorder.
  always @(negedge clk) begin
    if (mawg_kick === 1'b1)
      kick_q.push_back('{cyc, int'(mawg_repetition), int'(mawg_ctrl_length)});
    if (done !== 1'b0 || done_skipped !== 1'b0)
      done_q.push_back('{cyc, (done === 1'b1) ? int'(done_skipped) : 9});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Request-level timing: pop no earlier than push+1, the cycle after the previous done,
  // and the edge enable became 1; kick 2+d cycles after pop; done BUSY_N+2 after kick.
  function automatic void predict(int pc, int rep, int len, int d);
    int pop_c;
    int kick_c;
    pop_c = pc + 1;
    if (last_done + 1 > pop_c) pop_c = last_done + 1;
    if (en_edge > pop_c) pop_c = en_edge;
    kick_c = pop_c + 2 + d;
    if (rep == 0) begin
      exp_done.push_back('{kick_c, 1});
      last_done = kick_c;
    end else begin
      exp_kick.push_back('{kick_c, rep, len});
      exp_done.push_back('{kick_c + BUSY_N + 2, 0});
      last_done = kick_c + BUSY_N + 2;
    end
  endfunction

  task automatic push(int rep, int len, int d, output int pc, output bit acc);
    @(negedge clk);
    req_valid       = 1'b1;
    flush           = 1'b0;
    req_repetition  = 16'(rep);
    req_ctrl_length = LEN_W'(len);
    req_delay       = DELAY_WIDTH'(d);
    pc  = cyc + 1;
    acc = req_ready;
  endtask

  task automatic gap(int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
    end
  endtask

  task automatic wait_idle(string tag, int budget);
    int n;
    n = 0;
    gap(1);
    while (!(active === 1'b0 && pending === '0 && busy_cnt == 0 && mawg_kick === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idle_within_budget"}, n < budget, 1);
    gap(2);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, ".pending"}, pending, 0);
    check({tag, ".req_ready"}, req_ready, 1);
    check({tag, ".mawg_kick"}, mawg_kick, 0);
    check({tag, ".mawg_repetition"}, mawg_repetition, 0);
    check({tag, ".mawg_ctrl_length"}, mawg_ctrl_length, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".done_skipped"}, done_skipped, 0);
    check({tag, ".active"}, active, 0);
  endtask

  task automatic compare_events(string tag);
    int nk;
    int nek;
    int nd;
    int ned;
    nk  = kick_q.size() - kb;
    nek = exp_kick.size() - ekb;
    nd  = done_q.size() - db;
    ned = exp_done.size() - edb;
    check({tag, ".kick_count"}, nk, nek);
    for (int i = 0; i < nek && i < nk; i++) begin
      check($sformatf("%s.kick%0d_cycle", tag, i), kick_q[kb+i].c, exp_kick[ekb+i].c);
      check($sformatf("%s.kick%0d_rep", tag, i), kick_q[kb+i].rep, exp_kick[ekb+i].rep);
      check($sformatf("%s.kick%0d_len", tag, i), kick_q[kb+i].len, exp_kick[ekb+i].len);
    end
    check({tag, ".done_count"}, nd, ned);
    for (int i = 0; i < ned && i < nd; i++) begin
      check($sformatf("%s.done%0d_cycle", tag, i), done_q[db+i].c, exp_done[edb+i].c);
      check($sformatf("%s.done%0d_skipped", tag, i), done_q[db+i].skip, exp_done[edb+i].skip);
    end
    kb  = kick_q.size();
    ekb = exp_kick.size();
    db  = done_q.size();
    edb = exp_done.size();
  endtask

  initial begin
    int  pc;
    int  pc0;
    int  rel;
    bit  acc;
    bit  found;
    int  pcs [9];
    bit  accs [9];
    int  lens [9];

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b0;
    last_done = cyc;
    gap(1);
    check_reset_outputs("reset");
    enable = 1'b1;

    // S1: single request, delay 0
    push(2, 3, 0, pc, acc);
    check("s1.accepted", acc, 1);
    predict(pc, 2, 3, 0);
    gap(1);
    check("s1.pending_after_push", pending, 1);
    wait_idle("s1", 100);
    check("s1.kick_latency", (kick_q.size() > kb) ? kick_q[kb].c - pc : -1, 3);
    check("s1.pending_end", pending, 0);
    compare_events("s1");

    // S2a: delay 5 shifts the kick by 5
    push(2, 3, 5, pc, acc);
    predict(pc, 2, 3, 5);
    wait_idle("s2a", 100);
    check("s2a.kick_latency", (kick_q.size() > kb) ? kick_q[kb].c - pc : -1, 8);
    compare_events("s2a");

    // S2b: 9 back-to-back pushes with enable=0
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 9; i++) begin
      lens[i] = int'($urandom_range(0, 65535));
      push(i + 1, lens[i], i % 3, pcs[i], accs[i]);
    end
    gap(1);
    for (int i = 0; i < 9; i++) check($sformatf("s2b.accept%0d", i), accs[i], (i < 8) ? 1 : 0);
    check("s2b.pending_full", pending, 8);
    check("s2b.ready_full", req_ready, 0);
    @(negedge clk);
    enable  = 1'b1;
    en_edge = cyc + 1;
    for (int i = 0; i < 9; i++) if (accs[i]) predict(pcs[i], i + 1, lens[i], i % 3);
    wait_idle("s2b", 600);
    compare_events("s2b");

    // S3: repetition 0 between two normal requests
    push(7, 11, 1, pc, acc);
    predict(pc, 7, 11, 1);
    push(0, 5, 0, pc, acc);
    predict(pc, 0, 5, 0);
    push(1, 9, 2, pc, acc);
    predict(pc, 1, 9, 2);
    wait_idle("s3", 200);
    compare_events("s3");

    // S4: mawg busy when KICK is reached
    @(negedge clk);
    force_busy = 1'b1;
    push(3, 4, 0, pc, acc);
    gap(12);
    check("s4.kick_withheld", kick_q.size() - kb, 0);
    check("s4.active_while_held", active, 1);
    @(negedge clk);
    force_busy = 1'b0;
    rel = cyc + 1;
    exp_kick.push_back('{rel, 3, 4});
    exp_done.push_back('{rel + BUSY_N + 2, 0});
    last_done = rel + BUSY_N + 2;
    wait_idle("s4", 100);
    compare_events("s4");

    // S5: flush with 4 queued while one plays; a push in the flush cycle is dropped
    push(5, 6, 20, pc0, acc);
    predict(pc0, 5, 6, 20);
    for (int i = 0; i < 4; i++) push(100 + i, i, 0, pc, acc);
    @(negedge clk);
    check("s5.pending_before_flush", pending, 4);
    flush           = 1'b1;
    req_valid       = 1'b1;
    req_repetition  = 16'd77;
    req_ctrl_length = LEN_W'(77);
    req_delay       = '0;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    check("s5.pending_after_flush", pending, 0);
    check("s5.active_after_flush", active, 1);
    wait_idle("s5", 200);
    compare_events("s5");

    // S6: reset during WAIT with 3 queued
    push(1, 1, 0, pc0, acc);
    for (int i = 0; i < 3; i++) push(50 + i, 2, 0, pc, acc);
    exp_kick.push_back('{pc0 + 3, 1, 1});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mawg_kick === 1'b1) found = 1'b1;
    end
    check("s6.kick_seen", found, 1);
    check("s6.pending_in_wait", pending, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_done = cyc;
    check_reset_outputs("s6");
    gap(15);
    push(4, 2, 1, pc, acc);
    predict(pc, 4, 2, 1);
    wait_idle("s6", 100);
    compare_events("s6");

    // Randomized batches
    for (int b = 0; b < 4; b++) begin
      int n;
      n = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) begin
        int rep;
        int len;
        int d;
        rep = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 65535));
        len = int'($urandom_range(0, 65535));
        d   = int'($urandom_range(0, 9));
        gap(int'($urandom_range(0, 6)));
        push(rep, len, d, pc, acc);
        predict(pc, rep, len, d);
      end
      wait_idle($sformatf("rnd%0d", b), 400);
      compare_events($sformatf("rnd%0d", b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
